axi_basic_tx_mux: RTL and testbench

AXI_BASIC_TX_MUX -- requirements
Module: axi_basic_tx_mux

---
 rtl/axi_basic_tx_mux.sv | 184 ++++++++++++++++++
 tb/tb_axi_basic_tx_mux.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_basic_tx_mux.sv
// Arbitrates C_NUM_CH AXI-stream TX sources onto one TRN TX port, packet by packet.
// Optional macro AXI_TX_MUX_PRIO_EN: fixed priority (lowest index) instead of round-robin.
module axi_basic_tx_mux #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_NUM_CH     = 2,
  parameter int TCQ          = 1,
  localparam int STRB_WIDTH  = C_DATA_WIDTH / 8,
  localparam int REM_WIDTH   = (C_DATA_WIDTH == 128) ? 2 : 1
) (
  input  logic                               user_clk,
  input  logic                               user_rst_n,
  input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
  input  logic [C_NUM_CH-1:0]                s_axis_tx_tvalid,
  output logic [C_NUM_CH-1:0]                s_axis_tx_tready,
  input  logic [C_NUM_CH*STRB_WIDTH-1:0]     s_axis_tx_tkeep,
  input  logic [C_NUM_CH-1:0]                s_axis_tx_tlast,
  input  logic [C_NUM_CH*4-1:0]              s_axis_tx_tuser,
  output logic [C_DATA_WIDTH-1:0]            trn_td,
  output logic                               trn_tsof,
  output logic                               trn_teof,
  output logic                               trn_tsrc_rdy,
  output logic                               trn_tsrc_dsc,
  output logic                               trn_terrfwd,
  output logic                               trn_tstr,
  output logic                               trn_tecrc_gen,
  output logic [REM_WIDTH-1:0]               trn_trem,
  input  logic                               trn_tdst_rdy,
  input  logic [5:0]                         trn_tbuf_av,
  input  logic                               trn_lnk_up,
  output logic [1:0]                         tx_grant_ch
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t                  state_q;
  logic [1:0]              grant_q, last_q, pick;
  logic                    first_q;
  logic [C_DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0]   sel_keep;
  logic [3:0]              sel_user;
  logic                    sel_valid, sel_last;
  logic [REM_WIDTH-1:0]    sel_rem;
  logic                    rdy_grant, xfer_acc, held;
  logic                    unused_ok;

  // Granted-channel view of the source bus
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned c = 0; c < C_NUM_CH; c++) begin
      if (grant_q == 2'(c)) begin
        sel_data  = s_axis_tx_tdata[c*C_DATA_WIDTH +: C_DATA_WIDTH];
        sel_keep  = s_axis_tx_tkeep[c*STRB_WIDTH +: STRB_WIDTH];
        sel_user  = s_axis_tx_tuser[c*4 +: 4];
        sel_valid = s_axis_tx_tvalid[c];
        sel_last  = s_axis_tx_tlast[c];
      end
    end
  end

  generate
    if (C_DATA_WIDTH == 128) begin : g_rem128
      always_comb begin
        if (sel_keep[12])     sel_rem = REM_WIDTH'(3);
        else if (sel_keep[8]) sel_rem = REM_WIDTH'(2);
        else if (sel_keep[4]) sel_rem = REM_WIDTH'(1);
        else                  sel_rem = REM_WIDTH'(0);
      end
    end else begin : g_rem64
      assign sel_rem = sel_keep[4];
    end
  endgenerate

  assign unused_ok = ^{sel_keep, (TCQ != 0)};

  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    pick  = last_q;
`ifdef AXI_TX_MUX_PRIO_EN
    for (int unsigned i = 0; i < C_NUM_CH; i++) begin
      if (!found && s_axis_tx_tvalid[i]) begin
        pick  = 2'(i);
        found = 1'b1;
      end
    end
`else
    // Search starts one past the last granted channel, wrapping
    for (int unsigned i = 1; i <= C_NUM_CH; i++) begin
      idx = (int'(last_q) + i) % C_NUM_CH;
      if (!found && s_axis_tx_tvalid[idx]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
`endif
  end

  assign held      = trn_tsrc_rdy & ~trn_tdst_rdy;
  assign rdy_grant = ((state_q == XFER) & trn_lnk_up & ~held) | (state_q == DRAIN);
  assign xfer_acc  = (state_q == XFER) & trn_lnk_up & ~held & sel_valid;

  always_comb begin
    s_axis_tx_tready = '0;
    for (int unsigned c = 0; c < C_NUM_CH; c++) begin
      if (grant_q == 2'(c)) s_axis_tx_tready[c] = rdy_grant;
    end
  end

  assign tx_grant_ch = grant_q;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_q        <= 2'(C_NUM_CH - 1);
      first_q       <= 1'b0;
      trn_td        <= '0;
      trn_tsof      <= 1'b0;
      trn_teof      <= 1'b0;
      trn_tsrc_rdy  <= 1'b0;
      trn_tsrc_dsc  <= 1'b0;
      trn_terrfwd   <= 1'b0;
      trn_tstr      <= 1'b0;
      trn_tecrc_gen <= 1'b0;
      trn_trem      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|s_axis_tx_tvalid && trn_lnk_up && trn_tbuf_av != '0) begin
            state_q <= XFER;
            grant_q <= pick;
            first_q <= 1'b1;
          end
        end
        XFER: begin
          if (!trn_lnk_up) begin
            state_q <= DRAIN;
          end else if (xfer_acc && sel_last) begin
            state_q <= IDLE;
            last_q  <= grant_q;
          end
        end
        DRAIN: begin
          if (sel_valid && sel_last) begin
            state_q <= IDLE;
            last_q  <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (xfer_acc) begin
        trn_td        <= sel_data;
        trn_tsof      <= first_q;
        trn_teof      <= sel_last;
        trn_tsrc_rdy  <= 1'b1;
        trn_tsrc_dsc  <= sel_user[3];
        trn_tstr      <= sel_user[2];
        trn_terrfwd   <= sel_user[1];
        trn_tecrc_gen <= sel_user[0];
        trn_trem      <= sel_rem;
        first_q       <= 1'b0;
      end else if (state_q == XFER && !trn_lnk_up) begin
        // Link loss: tag a still-held beat, else emit a fresh terminating beat
        if (!held) begin
          trn_tsrc_rdy <= 1'b1;
          trn_tsof     <= first_q;
        end
        trn_teof     <= 1'b1;
        trn_tsrc_dsc <= 1'b1;
        first_q      <= 1'b0;
      end else if (trn_tsrc_rdy && trn_tdst_rdy) begin
        trn_tsrc_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_basic_tx_mux.sv
// Randomized bench for axi_basic_tx_mux (128-bit, 3 channels) against a packet-order reference model.
module tb_axi_basic_tx_mux;
  localparam int DW = 128, NCH = 3, SW = 16, MAXP = 8, MAXB = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NCH*DW-1:0]  s_axis_tx_tdata;
  logic [NCH-1:0]     s_axis_tx_tvalid, s_axis_tx_tready, s_axis_tx_tlast;
  logic [NCH*SW-1:0]  s_axis_tx_tkeep;
  logic [NCH*4-1:0]   s_axis_tx_tuser;
  logic [DW-1:0]      trn_td;
  logic               trn_tsof, trn_teof, trn_tsrc_rdy, trn_tsrc_dsc;
  logic               trn_terrfwd, trn_tstr, trn_tecrc_gen;
  logic [1:0]         trn_trem, tx_grant_ch;
  logic               trn_tdst_rdy, trn_lnk_up;
  logic [5:0]         trn_tbuf_av;

  always #5 clk = ~clk;

  axi_basic_tx_mux #(.C_DATA_WIDTH(DW), .C_NUM_CH(NCH), .TCQ(1)) dut (
    .user_clk(clk), .user_rst_n(rst_n),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tvalid(s_axis_tx_tvalid),
    .s_axis_tx_tready(s_axis_tx_tready), .s_axis_tx_tkeep(s_axis_tx_tkeep),
    .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tuser(s_axis_tx_tuser),
    .trn_td(trn_td), .trn_tsof(trn_tsof), .trn_teof(trn_teof),
    .trn_tsrc_rdy(trn_tsrc_rdy), .trn_tsrc_dsc(trn_tsrc_dsc),
    .trn_terrfwd(trn_terrfwd), .trn_tstr(trn_tstr), .trn_tecrc_gen(trn_tecrc_gen),
    .trn_trem(trn_trem), .trn_tdst_rdy(trn_tdst_rdy), .trn_tbuf_av(trn_tbuf_av),
    .trn_lnk_up(trn_lnk_up), .tx_grant_ch(tx_grant_ch)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    rem;
    logic [3:0]    u;
    logic          sof, eof, mark;
    int            ch;
  } beat_t;

  beat_t          expq[$];
  int             np[NCH], cp[NCH], cb[NCH];
  int             plen[NCH][MAXP];
  logic [DW-1:0]  pd[NCH][MAXP][MAXB];
  logic [SW-1:0]  pk[NCH][MAXP][MAXB];
  logic [3:0]     pu[NCH][MAXP][MAXB];
  int             rr_last;
  bit             gaps, rnd_dst, rnd_buf, chk_grant;
  bit             acc_prev, held_v;
  logic [DW-1:0]  acc_d, held_d;
  logic [7:0]     held_f;
  int             n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] keep2rem(input logic [SW-1:0] k);
    case (k)
      16'h000F: return 2'd0;
      16'h00FF: return 2'd1;
      16'h0FFF: return 2'd2;
      default:  return 2'd3;
    endcase
  endfunction

  task automatic reset_engine();
    for (int c = 0; c < NCH; c++) begin np[c] = 0; cp[c] = 0; cb[c] = 0; end
    expq.delete();
    acc_prev = 1'b0;
    held_v   = 1'b0;
  endtask

  task automatic add_pkt(input int c, input int len, input logic [SW-1:0] kforce);
    logic [SW-1:0] kt[4];
    int p;
    kt = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
    p = np[c];
    plen[c][p] = len;
    for (int b = 0; b < len; b++) begin
      pd[c][p][b] = {$urandom(), $urandom(), $urandom(), 32'(c*65536 + p*256 + b)};
      pk[c][p][b] = (kforce != '0) ? kforce : kt[$urandom_range(0, 3)];
      pu[c][p][b] = 4'($urandom());
    end
    np[c]++;
  endtask

  // Expected TRN order: whole packets, channel chosen by the arbitration rule
  task automatic build_expect();
    int left[NCH];
    int total, c, p;
    beat_t e;
    total = 0;
    for (int i = 0; i < NCH; i++) begin left[i] = np[i] - cp[i]; total += left[i]; end
    while (total > 0) begin
      c = -1;
`ifdef AXI_TX_MUX_PRIO_EN
      for (int i = NCH - 1; i >= 0; i--) if (left[i] > 0) c = i;
`else
      for (int i = NCH; i >= 1; i--) if (left[(rr_last + i) % NCH] > 0) c = (rr_last + i) % NCH;
`endif
      p = np[c] - left[c];
      for (int b = 0; b < plen[c][p]; b++) begin
        e.d = pd[c][p][b]; e.rem = keep2rem(pk[c][p][b]); e.u = pu[c][p][b];
        e.sof = (b == 0); e.eof = (b == plen[c][p] - 1); e.mark = 1'b0; e.ch = c;
        expq.push_back(e);
      end
      left[c]--; total--;
      rr_last = c;
    end
  endtask

  task automatic present();
    for (int c = 0; c < NCH; c++) begin
      if (cp[c] < np[c]) begin
        s_axis_tx_tdata[c*DW +: DW] = pd[c][cp[c]][cb[c]];
        s_axis_tx_tkeep[c*SW +: SW] = pk[c][cp[c]][cb[c]];
        s_axis_tx_tuser[c*4 +: 4]   = pu[c][cp[c]][cb[c]];
        s_axis_tx_tlast[c]          = (cb[c] == plen[c][cp[c]] - 1);
        s_axis_tx_tvalid[c]         = (cb[c] == 0) || !gaps || ($urandom_range(0, 3) != 0);
      end else begin
        s_axis_tx_tvalid[c] = 1'b0;
        s_axis_tx_tlast[c]  = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] acc;
    beat_t e;
    @(negedge clk);
    if (acc_prev) begin
      check("lat_srcrdy", trn_tsrc_rdy, 1);
      check("lat_td", trn_td, acc_d);
    end
    if (held_v) begin
      check("hold_td", trn_td, held_d);
      check("hold_flags", {trn_tsof, trn_teof, trn_trem, trn_tsrc_dsc, trn_tstr, trn_terrfwd, trn_tecrc_gen}, held_f);
    end
    if (trn_tsrc_rdy && trn_tdst_rdy) begin
      if (expq.size() == 0) check("extra_beat", 1, 0);
      else begin
        e = expq.pop_front();
        if (e.mark) begin
          check("dsc_eof", trn_teof, 1);
          check("dsc_flag", trn_tsrc_dsc, 1);
        end else begin
          check("td", trn_td, e.d);
          check("sof", trn_tsof, e.sof);
          check("eof", trn_teof, e.eof);
          check("rem", trn_trem, e.rem);
          check("user", {trn_tsrc_dsc, trn_tstr, trn_terrfwd, trn_tecrc_gen}, e.u);
          if (chk_grant && e.sof) check("grant", tx_grant_ch, e.ch);
        end
      end
    end
    held_v = trn_tsrc_rdy && !trn_tdst_rdy && trn_lnk_up;
    held_d = trn_td;
    held_f = {trn_tsof, trn_teof, trn_trem, trn_tsrc_dsc, trn_tstr, trn_terrfwd, trn_tecrc_gen};
    check("rdy_nongrant", s_axis_tx_tready & ~(3'b001 << tx_grant_ch), 0);
    if (trn_tsrc_rdy && !trn_tdst_rdy && trn_lnk_up) check("rdy_stall", s_axis_tx_tready, 0);
    acc = s_axis_tx_tvalid & s_axis_tx_tready;
    acc_prev = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c] && trn_lnk_up) begin acc_prev = 1'b1; acc_d = s_axis_tx_tdata[c*DW +: DW]; end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        cb[c]++;
        if (cb[c] == plen[c][cp[c]]) begin cb[c] = 0; cp[c]++; end
      end
    end
    present();
    if (rnd_dst) trn_tdst_rdy = ($urandom_range(0, 9) < 7);
    if (rnd_buf) trn_tbuf_av = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
  endtask

  function automatic bit all_sent();
    for (int c = 0; c < NCH; c++) if (cp[c] < np[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!(all_sent() && expq.size() == 0 && !trn_tsrc_rdy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("timeout", 0, 1);
  endtask

  task automatic run_until_beat(input int c, input int b);
    int n = 0;
    while (cb[c] != b && n < 50) begin step(); n++; end
    if (n >= 50) check("beat_timeout", 0, 1);
  endtask

  initial begin
    beat_t m;
    rst_n = 1'b0;
    s_axis_tx_tdata = '0; s_axis_tx_tkeep = '0; s_axis_tx_tuser = '0;
    s_axis_tx_tlast = '0; s_axis_tx_tvalid = '1;
    trn_tdst_rdy = 1'b1; trn_lnk_up = 1'b1; trn_tbuf_av = 6'd8;
    gaps = 0; rnd_dst = 0; rnd_buf = 0; chk_grant = 0;
    rr_last = NCH - 1;
    reset_engine();
    repeat (3) @(posedge clk);
    #1;
    check("rst_srcrdy", trn_tsrc_rdy, 0);
    check("rst_sofeof", {trn_tsof, trn_teof}, 0);
    check("rst_td", trn_td, 0);
    check("rst_flags", {trn_trem, trn_tsrc_dsc, trn_tstr, trn_terrfwd, trn_tecrc_gen}, 0);
    check("rst_tready", s_axis_tx_tready, 0);
    check("rst_grant", tx_grant_ch, 0);
    s_axis_tx_tvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back 3-beat packets on ch0 and ch1
    add_pkt(0, 3, '0); add_pkt(0, 3, '0); add_pkt(1, 3, '0); add_pkt(1, 3, '0);
    build_expect();
    chk_grant = 1;
    present();
    run_until_done(200);
    chk_grant = 0;

    // Single 128-bit beat with three valid DWs
    reset_engine();
    add_pkt(2, 1, 16'h0FFF);
    build_expect();
    present();
    run_until_done(50);

    // Three-cycle sink stall mid-packet
    reset_engine();
    add_pkt(0, 4, '0);
    build_expect();
    present();
    step(); step();
    trn_tdst_rdy = 1'b0;
    step(); step(); step();
    trn_tdst_rdy = 1'b1;
    run_until_done(50);

    // Link loss after beat 2 of 5
    reset_engine();
    add_pkt(0, 5, '0);
    build_expect();
    repeat (3) void'(expq.pop_back());
    m = '{d: '0, rem: '0, u: '0, sof: 1'b0, eof: 1'b1, mark: 1'b1, ch: 0};
    expq.push_back(m);
    present();
    run_until_beat(0, 2);
    trn_lnk_up = 1'b0;
    run_until_done(50);
    check("drain_idle", s_axis_tx_tready, 0);
    trn_lnk_up = 1'b1;

    // No buffer credit: no new grant until tbuf_av returns
    reset_engine();
    trn_tbuf_av = 6'd0;
    add_pkt(1, 2, '0);
    build_expect();
    present();
    for (int i = 0; i < 4; i++) begin
      step();
      check("buf_rdy", s_axis_tx_tready, 0);
      check("buf_grant", tx_grant_ch, 0);
    end
    trn_tbuf_av = 6'd4;
    step();
    check("buf_grant_on", tx_grant_ch, 1);
    check("buf_rdy_on", s_axis_tx_tready, 3'b010);
    run_until_done(50);

    // Randomized traffic: gaps, sink backpressure, credit drops
    for (int r = 0; r < 3; r++) begin
      reset_engine();
      for (int c = 0; c < NCH; c++) begin
        int k = $urandom_range(3, 6);
        for (int p = 0; p < k; p++) add_pkt(c, $urandom_range(1, 4), '0);
      end
      build_expect();
      gaps = 1; rnd_dst = 1; rnd_buf = 1;
      present();
      run_until_done(3000);
      gaps = 0; rnd_dst = 0; rnd_buf = 0;
      trn_tdst_rdy = 1'b1; trn_tbuf_av = 6'd8;
      step();
    end

    // Reset mid-packet, then fresh traffic restarts at ch0
    reset_engine();
    add_pkt(2, 4, '0);
    build_expect();
    present();
    run_until_beat(2, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_srcrdy", trn_tsrc_rdy, 0);
    check("mrst_sofeof", {trn_tsof, trn_teof}, 0);
    check("mrst_td", trn_td, 0);
    check("mrst_tready", s_axis_tx_tready, 0);
    check("mrst_grant", tx_grant_ch, 0);
    reset_engine();
    s_axis_tx_tvalid = '0;
    rr_last = NCH - 1;
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(1, 2, '0); add_pkt(0, 1, '0); add_pkt(2, 2, '0);
    build_expect();
    chk_grant = 1;
    present();
    run_until_done(100);
    chk_grant = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
